// File: rtl/rx_fifo_pkg.sv
// Shared definitions for the router, transceiver and rx_fifo: data width
// macro, default FIFO depth and the two-phase handshake helper.
`ifndef SIZE
`define SIZE 8
`endif

package rx_fifo_pkg;

   localparam int unsigned DEFAULT_DEPTH = 4;

   // A two-phase channel is pending when request and acknowledge disagree.
   function automatic logic pending(input logic req, input logic ack);
      return req ^ ack;
   endfunction

endpackage

// File: rtl/rx_fifo_mem.sv
// fifo_mem: DEPTH x WIDTH storage with one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module fifo_mem #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/rx_fifo.sv
// rx_fifo: two-phase link receiver buffering items into fifo_mem and
// presenting them to the router over a registered two-phase handshake.
`ifndef SIZE
`define SIZE 8
`endif

module rx_fifo
   import rx_fifo_pkg::*;
#(
   parameter int          id    = -1,
   parameter string       port  = "unknown",
   parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_in,
   output logic                   ack_in,
   input  logic [`SIZE-1:0]       data_in,
   output logic                   req_out,
   input  logic                   ack_out,
   output logic [`SIZE-1:0]       data_out,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [`SIZE-1:0] head;
   logic             accept;
   logic             launch;
   logic             wr_en;

   // Full and empty are judged on the pre-edge count, so a launch never
   // opens a slot for a write in the same cycle.
   always_comb begin
      accept = pending(req_in, ack_in) && (count != FULL);
      launch = !pending(req_out, ack_out) && (count != '0);
      wr_en  = accept && !reset;
   end

   fifo_mem #(
      .DEPTH (DEPTH),
      .WIDTH (`SIZE)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (data_in),
      .rd_addr (rd_ptr),
      .rd_data (head)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         ack_in   <= 1'b0;
         req_out  <= 1'b0;
         data_out <= '0;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + PW'(1);
            ack_in <= ~ack_in;
         end
         if (launch) begin
            data_out <= head;
            rd_ptr   <= rd_ptr + PW'(1);
            req_out  <= ~req_out;
         end
         case ({accept, launch})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
